// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic inter-stage pipeline buffer.
// Moves one payload word and one control field from one stage to the next,
// using a valid/ready handshake. It has stall and flush controls and an
// optional second (skid) entry. A slot that holds no valid entry always
// presents zero control bits. This stops a bubble from triggering a register
// or memory write further down the pipeline.
// All state updates on the falling clock edge. Reset is asynchronous and
// active-low.

module pipe_stage_buf #(
  parameter int DATA_W = 56,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  // Occupancy state. The encoding is the entry count, so count is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } bufState_e;

  bufState_e         state_q, state_d;
  logic [DATA_W-1:0] headData_q, headData_d;
  logic [CTRL_W-1:0] headCtrl_q, headCtrl_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
  logic              inReady_q, inReady_d;
  logic              push;
  logic              pop;

  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;
  assign out_data  = headData_q;

  // Mask the control bits of an empty slot so a bubble can never write anything downstream.
  assign out_ctrl  = out_valid ? headCtrl_q : '0;

  // A pop needs a valid head, a consuming successor and no stall.
  // Flush outranks every other event and is handled in the next-state logic.
  assign pop  = out_valid & out_ready & ~stall;
  assign push = in_valid & in_ready;

  // Select how in_ready is produced: registered with the skid entry, combinational without it.
  generate
    if (SKID != 0) begin : g_skidReady
      assign in_ready = inReady_q;
    end else begin : g_passReady
      assign in_ready = ~out_valid | (out_ready & ~stall);
    end
  endgenerate

  // Next-state logic: occupancy transitions, head/skid loading and the registered ready.
  always_comb begin
    state_d    = state_q;
    headData_d = headData_q;
    headCtrl_d = headCtrl_q;
    skidData_d = skidData_q;
    skidCtrl_d = skidCtrl_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d    = ONE;
            headData_d = in_data;
            headCtrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && pop) begin
            headData_d = in_data;
            headCtrl_d = in_ctrl;
          end else if (push && (SKID != 0)) begin
            state_d    = FULL;
            skidData_d = in_data;
            skidCtrl_d = in_ctrl;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d    = ONE;
            headData_d = skidData_q;
            headCtrl_d = skidCtrl_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    inReady_d = (state_d != FULL);
  end

  // State registers: falling-edge update, asynchronous active-low clear of every entry.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      headData_q <= '0;
      headCtrl_q <= '0;
      skidData_q <= '0;
      skidCtrl_q <= '0;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      headData_q <= headData_d;
      headCtrl_q <= headCtrl_d;
      skidData_q <= skidData_d;
      skidCtrl_q <= skidCtrl_d;
      inReady_q  <= inReady_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf.
// It drives two instances: one with the skid entry enabled and one without.
// Stimulus pushes each accepted entry into a per-instance expectation queue.
// A monitor on the rising edge pops that queue and compares it with the head
// whenever a handshake will complete at the next falling edge.

module tb_pipe_stage_buf;

  typedef struct packed {
    logic [55:0] data;
    logic [2:0]  ctrl;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        sStall = 1'b0, sFlush = 1'b0, sInValid = 1'b0, sOutReady = 1'b0;
  logic [55:0] sInData = '0;
  logic [2:0]  sInCtrl = '0;
  logic        sInReady, sOutValid;
  logic [55:0] sOutData;
  logic [2:0]  sOutCtrl;
  logic [1:0]  sCount;

  logic        nStall = 1'b0, nFlush = 1'b0, nInValid = 1'b0, nOutReady = 1'b0;
  logic [55:0] nInData = '0;
  logic [2:0]  nInCtrl = '0;
  logic        nInReady, nOutValid;
  logic [55:0] nOutData;
  logic [2:0]  nOutCtrl;
  logic [1:0]  nCount;

  entry_t sExpQ[$];
  entry_t nExpQ[$];

  int vectorsApplied = 0;
  int miscompares = 0;

  pipe_stage_buf #(.DATA_W(56), .CTRL_W(3), .SKID(1)) dutSkid (
    .clk(clk), .reset(reset), .stall(sStall), .flush(sFlush),
    .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData), .in_ctrl(sInCtrl),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData),
    .out_ctrl(sOutCtrl), .count(sCount)
  );

  pipe_stage_buf #(.DATA_W(56), .CTRL_W(3), .SKID(0)) dutPass (
    .clk(clk), .reset(reset), .stall(nStall), .flush(nFlush),
    .in_valid(nInValid), .in_ready(nInReady), .in_data(nInData), .in_ctrl(nInCtrl),
    .out_valid(nOutValid), .out_ready(nOutReady), .out_data(nOutData),
    .out_ctrl(nOutCtrl), .count(nCount)
  );

  // Free-running clock; the design updates on the falling edge.
  initial forever #5 clk = ~clk;

  // One comparison: count it and report a miscompare.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs to the chosen instance and step past the falling edge.
  // Then record the hand-determined outcome in that instance's expectation queue.
  task automatic applyStimulus(input bit noSkid, input bit valid, input logic [55:0] data,
                               input logic [2:0] ctrl, input bit outReady, input bit stallIn,
                               input bit flushIn, input bit expAccept);
    entry_t e;
    e.data = data;
    e.ctrl = ctrl;
    if (noSkid) begin
      nInValid = valid; nInData = data; nInCtrl = ctrl;
      nOutReady = outReady; nStall = stallIn; nFlush = flushIn;
    end else begin
      sInValid = valid; sInData = data; sInCtrl = ctrl;
      sOutReady = outReady; sStall = stallIn; sFlush = flushIn;
    end
    @(negedge clk);
    #1;
    if (flushIn) begin
      if (noSkid) nExpQ.delete(); else sExpQ.delete();
    end else if (valid && expAccept) begin
      if (noSkid) nExpQ.push_back(e); else sExpQ.push_back(e);
    end
  endtask

  // Monitor for the skid instance: check the head whenever the next falling edge will consume it.
  always @(posedge clk) begin
    if (reset && sOutValid && sOutReady && !sStall && !sFlush) begin
      if (sExpQ.size() == 0) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL sUnexpected: got data 0x%0h, expected no valid entry", sOutData);
      end else begin
        entry_t e;
        e = sExpQ.pop_front();
        checkOutput("sHeadData", 64'(sOutData), 64'(e.data));
        checkOutput("sHeadCtrl", 64'(sOutCtrl), 64'(e.ctrl));
      end
    end
  end

  // Monitor for the pass-through instance, same rule.
  always @(posedge clk) begin
    if (reset && nOutValid && nOutReady && !nStall && !nFlush) begin
      if (nExpQ.size() == 0) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL nUnexpected: got data 0x%0h, expected no valid entry", nOutData);
      end else begin
        entry_t e;
        e = nExpQ.pop_front();
        checkOutput("nHeadData", 64'(nOutData), 64'(e.data));
        checkOutput("nHeadCtrl", 64'(nOutCtrl), 64'(e.ctrl));
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed sequence.
  initial begin
    #1 reset = 1'b0;
    #1;
    checkOutput("rstOutValid", 64'(sOutValid), 64'd0);
    checkOutput("rstOutData",  64'(sOutData),  64'd0);
    checkOutput("rstOutCtrl",  64'(sOutCtrl),  64'd0);
    checkOutput("rstCount",    64'(sCount),    64'd0);
    checkOutput("rstInReadyS", 64'(sInReady),  64'd1);
    checkOutput("rstInReadyN", 64'(nInReady),  64'd1);
    @(negedge clk);
    #1 reset = 1'b1;

    // Single push with an immediate consumer.
    applyStimulus(0, 1, 56'hAB, 3'b101, 1, 0, 0, 1);
    checkOutput("t1OutValid", 64'(sOutValid), 64'd1);
    checkOutput("t1OutData",  64'(sOutData),  64'hAB);
    checkOutput("t1OutCtrl",  64'(sOutCtrl),  64'd5);
    checkOutput("t1Count",    64'(sCount),    64'd1);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t1Drained",  64'(sCount),    64'd0);
    checkOutput("t1EmptyCtrl", 64'(sOutCtrl), 64'd0);

    // Fill the skid entry, then drain it in order.
    applyStimulus(0, 1, 56'h11, 3'b001, 0, 0, 0, 1);
    checkOutput("t2CountOne", 64'(sCount), 64'd1);
    applyStimulus(0, 1, 56'h22, 3'b010, 0, 0, 0, 1);
    checkOutput("t2CountFull", 64'(sCount), 64'd2);
    checkOutput("t2InReadyLow", 64'(sInReady), 64'd0);
    checkOutput("t2HeadA", 64'(sOutData), 64'h11);
    sOutReady = 1'b1;
    #1;
    checkOutput("t2ReadyRegistered", 64'(sInReady), 64'd0);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t2CountAfterA", 64'(sCount), 64'd1);
    checkOutput("t2HeadB", 64'(sOutData), 64'h22);
    checkOutput("t2InReadyBack", 64'(sInReady), 64'd1);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t2CountAfterB", 64'(sCount), 64'd0);

    // Stall holds the head, but free capacity still accepts a push.
    applyStimulus(0, 1, 56'h5A5A, 3'b111, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, (i == 2), 56'h77, 3'b011, 1, 1, 0, (i == 2));
      checkOutput("t3HeldData", 64'(sOutData), 64'h5A5A);
      checkOutput("t3HeldCount", 64'(sCount), (i == 2) ? 64'd2 : 64'd1);
    end
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t3AfterStallCount", 64'(sCount), 64'd1);
    checkOutput("t3AfterStallHead", 64'(sOutData), 64'h77);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t3Drained", 64'(sCount), 64'd0);

    // Flush a full buffer while a new entry is offered.
    applyStimulus(0, 1, 56'h31, 3'b001, 0, 0, 0, 1);
    applyStimulus(0, 1, 56'h32, 3'b010, 0, 0, 0, 1);
    checkOutput("t4CountFull", 64'(sCount), 64'd2);
    applyStimulus(0, 1, 56'hCC, 3'b110, 0, 0, 1, 0);
    checkOutput("t4OutValid", 64'(sOutValid), 64'd0);
    checkOutput("t4OutCtrl",  64'(sOutCtrl),  64'd0);
    checkOutput("t4Count",    64'(sCount),    64'd0);
    checkOutput("t4InReady",  64'(sInReady),  64'd1);
    applyStimulus(0, 1, 56'hD0, 3'b100, 0, 0, 0, 1);
    applyStimulus(0, 1, 56'hE0, 3'b111, 1, 0, 1, 0);
    checkOutput("t4FlushReadyDrop", 64'(sCount), 64'd0);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t4StillEmpty", 64'(sOutValid), 64'd0);

    // Asynchronous reset while full.
    applyStimulus(0, 1, 56'hF1, 3'b001, 0, 0, 0, 1);
    applyStimulus(0, 1, 56'hF2, 3'b010, 0, 0, 0, 1);
    sInValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    sExpQ.delete();
    checkOutput("t5OutValid", 64'(sOutValid), 64'd0);
    checkOutput("t5OutCtrl",  64'(sOutCtrl),  64'd0);
    checkOutput("t5Count",    64'(sCount),    64'd0);
    checkOutput("t5InReady",  64'(sInReady),  64'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 1, 56'h99, 3'b011, 1, 0, 0, 1);
    checkOutput("t5Recovered", 64'(sOutData), 64'h99);
    applyStimulus(0, 0, 56'h0, 3'b000, 1, 0, 0, 0);

    // Pass-through instance: back-to-back stream with no bubbles.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, 56'(i), 3'(i), 1, 0, 0, 1);
      checkOutput("t6StreamData",  64'(nOutData),  64'(i));
      checkOutput("t6StreamValid", 64'(nOutValid), 64'd1);
    end
    nInValid = 1'b0;
    nOutReady = 1'b0;
    #1;
    checkOutput("t6ReadyComb", 64'(nInReady), 64'd0);
    applyStimulus(1, 1, 56'h9, 3'b001, 0, 0, 0, 0);
    checkOutput("t6BlockedHead",  64'(nOutData), 64'h8);
    checkOutput("t6BlockedCount", 64'(nCount),   64'd1);
    applyStimulus(1, 1, 56'h9, 3'b001, 1, 0, 0, 1);
    checkOutput("t6Replaced", 64'(nOutData), 64'h9);
    applyStimulus(1, 0, 56'h0, 3'b000, 1, 1, 0, 0);
    checkOutput("t6StallHold", 64'(nCount), 64'd1);
    checkOutput("t6StallReady", 64'(nInReady), 64'd0);
    applyStimulus(1, 0, 56'h0, 3'b000, 1, 0, 0, 0);
    checkOutput("t6Drained", 64'(nCount), 64'd0);
    checkOutput("t6ReadyEmpty", 64'(nInReady), 64'd1);

    checkOutput("sQueueDrained", 64'(sExpQ.size()), 64'd0);
    checkOutput("nQueueDrained", 64'(nExpQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
